mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates one shared memory port between the core's instruction-fetch requester and its load/store data requester. It sits between the control unit's fetch and memory stages and the flash/SRAM controllers. It serializes accesses through a four-state FSM, applies round-robin fairness under contention, and aborts hung accesses with a timeout. Its `arb_busy` output feeds the control unit's memory-busy term.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byte enables are DW/8 bits)
- `TIMEOUT`, 255, maximum WAIT cycles before abort; legal range 1..1023; counter is 10 bits

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; level, held with stable `if_addr` until `if_ack`
- `if_addr`  in  AW  fetch address (always a read, all byte enables set)
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  DW  fetch data, valid while `if_ack`=1
- `d_req`  in  1  data request; level, held stable until `d_ack`
- `d_we`  in  1  1=write, 0=read
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_be`  in  DW/8  byte enables
- `d_ack`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  DW  read data, valid while `d_ack`=1
- `mem_start`  out  1  one-cycle access strobe to the memory controller
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/AW/DW/DW/8  registered access fields, stable from ISSUE through WAIT
- `mem_busy`  in  1  memory controller busy; raised at the edge that samples `mem_start`
- `mem_rdata`  in  DW  read data, valid in the first WAIT cycle with `mem_busy`=0
- `bus_err`  out  1  pulse coincident with an ack when that access timed out
- `arb_busy`  out  1  1 whenever the state is not IDLE

## Operation
- States:
  - IDLE: arbitrate. Any request moves to ISSUE, latching the winner's fields and `grant`.
  - ISSUE: `mem_start`=1; go to WAIT and clear the timeout counter.
  - WAIT:
    - `mem_busy`=0: capture `mem_rdata` and go to RESP.
    - Otherwise the counter increments. When it reaches `TIMEOUT`, go to RESP with `err`=1 and captured data 0.
  - RESP: assert the granted ack (plus `bus_err` if `err` is set), set `last_grant`=`grant`, return to IDLE.
- Arbitration:
  - Single request: it wins.
  - Both requests: the one not equal to `last_grant` wins.
  - `last_grant` resets to FETCH, so the first contention goes to data.
- Fetch accesses: `mem_we`=0, `mem_be`=all ones, `mem_wdata`=0.
- Data writes: captured read data is ignored, and `d_rdata` is driven 0 during ack.
- `if_rdata` and `d_rdata` hold their last value outside ack.
- Requests sampled in RESP are ignored. A `req` still high in IDLE after its ack is a new request, so back-to-back accesses are permitted.
- Changes to a requester's fields after grant have no effect; fields are latched in IDLE.
- `mem_busy` is ignored outside WAIT.
- Reset, including mid-access:
  - state=IDLE, `last_grant`=FETCH, counter=0, err=0.
  - All outputs 0.
  - The in-flight access is dropped with no ack. The memory controller is reset by the same `rst`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum latency: request high in IDLE at cycle 0 → ISSUE cycle 1 → WAIT cycle 2 → ack in cycle 3 (zero-wait memory).
- Each memory busy cycle adds one cycle.
- Timeout: ack occurs TIMEOUT+3 cycles after the request is sampled, with `bus_err`=1.
- Exactly one ack per grant. `if_ack` and `d_ack` are never high together.
- `mem_start` is high for exactly one cycle per access. Minimum spacing between strobes is 4 cycles.
- `arb_busy` is high from the cycle after a request is accepted through the RESP cycle inclusive.

## Test plan
- Reset then single fetch, `if_addr`=0x100, memory zero-wait returning 0xE7FE_4770: `mem_start` in cycle 1; `if_ack`=1 and `if_rdata`=0xE7FE4770 in cycle 3; `arb_busy` high in cycles 1–3.
- `if_req` and `d_req` both asserted and held continuously, each new request accepted immediately: grants alternate D, F, D, F; each ack 4 cycles apart; no simultaneous acks.
- Data write `d_addr`=0x2000_0004, `d_wdata`=0xA5A5_0000, `d_be`=4'b1100, `mem_busy` high 3 cycles: `mem_we`=1 with the fields held stable; `d_ack` in cycle 6; `d_rdata`=0.
- `mem_busy` stuck high with `TIMEOUT`=8: ack and `bus_err` pulse together at cycle 11; rdata=0; the next request is serviced normally.
- `rst` asserted during WAIT of a data read: all outputs 0 immediately; no `d_ack`; after release, a pending fetch is granted first with normal latency.
- Fetch request arrives while a data access is in WAIT: the fetch is ignored until IDLE, then granted; `if_addr` changed during the wait is sampled at the IDLE cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory controller port between the instruction-fetch requester
// and the load/store data requester. Accesses are serialised through an
// IDLE -> ISSUE -> WAIT -> RESP sequence. Simultaneous requests are resolved
// round-robin against the last granted requester, and an access whose memory
// stays busy too long is aborted with a bus error.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   if_req/if_addr      fetch request (always a full-word read)
//   if_ack/if_rdata     fetch completion pulse and read data
//   d_req/d_we/d_addr/d_wdata/d_be   data request fields
//   d_ack/d_rdata       data completion pulse and read data (0 for writes)
//   mem_start           one-cycle access strobe to the memory controller
//   mem_we/mem_addr/mem_wdata/mem_be registered access fields
//   mem_busy/mem_rdata  memory controller status and read data
//   bus_err             pulses with the ack of a timed-out access
//   arb_busy            high whenever an access is in progress
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_start,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_busy,
    input  logic [DW-1:0]   mem_rdata,
    output logic            bus_err,
    output logic            arb_busy
);

    localparam int         BW        = DW / 8;
    localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);
    localparam logic       GNT_FETCH = 1'b0;
    localparam logic       GNT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic [9:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            winner;

    logic            mem_start_q, mem_start_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic            if_ack_q, if_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            bus_err_q, bus_err_d;
    logic            arb_busy_q, arb_busy_d;

    // Round-robin pick: under contention the requester not served last wins.
    always_comb begin
        if (if_req && d_req) begin
            winner = (last_grant_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (d_req) begin
            winner = GNT_DATA;
        end else begin
            winner = GNT_FETCH;
        end
    end

    // FSM state register together with grant, round-robin and timeout state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_FETCH;
            last_grant_q <= GNT_FETCH;
            cnt_q        <= 10'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d = ST_ISSUE;
                    grant_d = winner;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = 10'd0;
                err_d   = 1'b0;
            end
            ST_WAIT: begin
                // A ready memory beats the timeout in the same cycle.
                if (!mem_busy) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                last_grant_d = grant_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, computed one cycle ahead so every output is a flop.
    always_comb begin
        mem_start_d = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = 1'b0;
        arb_busy_d  = (state_d != ST_IDLE);

        // Latch the winner's fields as the access is accepted.
        if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
            mem_start_d = 1'b1;
            if (grant_d == GNT_DATA) begin
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_be_d    = d_be;
            end else begin
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wdata_d = {DW{1'b0}};
                mem_be_d    = {BW{1'b1}};
            end
        end else begin
            mem_start_d = 1'b0;
        end

        // Completion: ack, read data and error land together in RESP.
        if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
            bus_err_d = err_d;
            if (grant_q == GNT_DATA) begin
                d_ack_d   = 1'b1;
                d_rdata_d = (err_d || mem_we_q) ? {DW{1'b0}} : mem_rdata;
            end else begin
                if_ack_d   = 1'b1;
                if_rdata_d = err_d ? {DW{1'b0}} : mem_rdata;
            end
        end else begin
            bus_err_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_start_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            mem_be_q    <= {BW{1'b0}};
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= {DW{1'b0}};
            d_rdata_q   <= {DW{1'b0}};
            bus_err_q   <= 1'b0;
            arb_busy_q  <= 1'b0;
        end else begin
            mem_start_q <= mem_start_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

    assign mem_start = mem_start_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_bus_arbiter: a timing-rule model checks every
// output each cycle, and directed scenarios pin literal expectations.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_busy;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic        arb_busy;

    int          checks = 0;
    int          errors = 0;

    // Memory controller stand-in: busy for cfg_busy cycles after each strobe.
    int          cfg_busy;
    logic [31:0] cfg_rdata;
    int          rem;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .arb_busy(arb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rem <= 0;
        else if (mem_start) rem <= cfg_busy;
        else if (rem != 0) rem <= rem - 1;
    end
    assign mem_busy  = (rem != 0);
    assign mem_rdata = cfg_rdata;

    logic [137:0] all_out;
    assign all_out = {mem_start, if_ack, d_ack, bus_err, arb_busy, mem_we, mem_be,
                      mem_addr, mem_wdata, if_rdata, d_rdata};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access accepted at cycle a strobes at a+1 and acks at
    // a+3+min(busy, TO) (error if busy exceeds TO); busy spans a+1..ack.
    int          mc;
    bit          m_act, m_gd, m_we, m_err, m_last_d;
    int          m_acc, m_ack;
    logic [31:0] m_rd;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_ifr, exp_dr;
    logic        e_start, e_busy, e_ifack, e_dack, e_err, at_ack;

    initial begin
        mc = 0; m_act = 1'b0; m_last_d = 1'b0; m_gd = 1'b0; m_we = 1'b0; m_err = 1'b0;
        m_acc = 0; m_ack = 0; m_rd = 32'd0;
        exp_we = 1'b0; exp_be = 4'd0; exp_addr = 32'd0; exp_wdata = 32'd0;
        exp_ifr = 32'd0; exp_dr = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_act = 1'b0; m_last_d = 1'b0;
                exp_we = 1'b0; exp_be = 4'd0; exp_addr = 32'd0; exp_wdata = 32'd0;
                exp_ifr = 32'd0; exp_dr = 32'd0;
            end
            at_ack  = m_act && (mc == m_ack);
            e_start = m_act && (mc == m_acc + 1);
            e_busy  = m_act && (mc > m_acc) && (mc <= m_ack);
            e_ifack = at_ack && !m_gd;
            e_dack  = at_ack && m_gd;
            e_err   = at_ack && m_err;
            if (at_ack) begin
                if (m_gd) exp_dr = (m_err || m_we) ? 32'd0 : m_rd;
                else      exp_ifr = m_err ? 32'd0 : m_rd;
            end
            chk("model_ctrl", {mem_start, if_ack, d_ack, bus_err, arb_busy},
                {e_start, e_ifack, e_dack, e_err, e_busy});
            chk("model_fields", {mem_we, mem_be, mem_addr, mem_wdata},
                {exp_we, exp_be, exp_addr, exp_wdata});
            chk("model_if_rdata", if_rdata, exp_ifr);
            chk("model_d_rdata", d_rdata, exp_dr);
            if (!rst) begin
                if (at_ack) begin
                    m_act = 1'b0;
                    m_last_d = m_gd;
                end else if (!m_act && (if_req || d_req)) begin
                    m_gd  = (if_req && d_req) ? !m_last_d : d_req;
                    m_acc = mc;
                    m_ack = mc + 3 + ((cfg_busy <= TO) ? cfg_busy : TO);
                    m_err = (cfg_busy > TO);
                    m_rd  = cfg_rdata;
                    if (m_gd) begin
                        exp_we = d_we; exp_be = d_be; exp_addr = d_addr; exp_wdata = d_wdata;
                    end else begin
                        exp_we = 1'b0; exp_be = 4'hF; exp_addr = if_addr; exp_wdata = 32'd0;
                    end
                    m_we  = exp_we;
                    m_act = 1'b1;
                end
            end
            mc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; cfg_busy = 0; cfg_rdata = 32'd0;
        repeat (3) at_sample();
        chk("reset_outputs", all_out, 160'd0);

        // Single zero-wait fetch right after reset release.
        cyc_edge();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; cfg_busy = 0; cfg_rdata = 32'hE7FE4770;
        for (int i = 0; i < 5; i++) begin
            at_sample();
            chk("t1_mem_start", mem_start, (i == 1));
            chk("t1_arb_busy", arb_busy, (i >= 1 && i <= 3));
            chk("t1_if_ack", if_ack, (i == 3));
            if (i == 1) chk("t1_mem_addr", {mem_addr, mem_be}, {32'h100, 4'hF});
            if (i == 3) chk("t1_if_rdata", if_rdata, 32'hE7FE4770);
            cyc_edge();
            if (i == 3) if_req = 1'b0;
        end

        // Continuous contention: D, F, D, F every 4 cycles.
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20000000;
        for (int i = 0; i < 17; i++) begin
            at_sample();
            chk("t2_d_ack", d_ack, (i == 3 || i == 11));
            chk("t2_if_ack", if_ack, (i == 7 || i == 15));
            chk("t2_mem_start", mem_start, (i % 4 == 1) && (i < 16));
            if (i == 1) chk("t2_grant_d", mem_addr, 32'h20000000);
            if (i == 5) chk("t2_grant_f", mem_addr, 32'h200);
            cyc_edge();
            if (i == 15) begin if_req = 1'b0; d_req = 1'b0; end
        end

        // Data write with three busy cycles.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20000004; d_wdata = 32'hA5A50000;
        d_be = 4'b1100; cfg_busy = 3;
        for (int i = 0; i < 8; i++) begin
            at_sample();
            if (i >= 1 && i <= 5)
                chk("t3_fields", {mem_we, mem_be, mem_addr, mem_wdata},
                    {1'b1, 4'b1100, 32'h20000004, 32'hA5A50000});
            chk("t3_d_ack", d_ack, (i == 6));
            if (i == 6) chk("t3_d_rdata", d_rdata, 32'd0);
            cyc_edge();
            if (i == 6) begin d_req = 1'b0; d_we = 1'b0; end
        end

        // Stuck-busy memory: timeout at TO+3 with bus_err.
        cfg_busy = 50; if_req = 1'b1; if_addr = 32'h300;
        for (int i = 0; i < 13; i++) begin
            at_sample();
            chk("t4_if_ack", if_ack, (i == 11));
            chk("t4_bus_err", bus_err, (i == 11));
            chk("t4_arb_busy", arb_busy, (i >= 1 && i <= 11));
            if (i == 11) chk("t4_if_rdata", if_rdata, 32'd0);
            cyc_edge();
            if (i == 11) if_req = 1'b0;
        end

        // Following access completes normally.
        cfg_busy = 1; cfg_rdata = 32'h12345678; d_req = 1'b1; d_addr = 32'h20000010;
        for (int i = 0; i < 6; i++) begin
            at_sample();
            chk("t4b_d_ack", d_ack, (i == 4));
            chk("t4b_bus_err", bus_err, 1'b0);
            if (i == 4) chk("t4b_d_rdata", d_rdata, 32'h12345678);
            cyc_edge();
            if (i == 4) d_req = 1'b0;
        end

        // Reset in WAIT of a data read, then a pending fetch.
        cfg_busy = 5; cfg_rdata = 32'h55AA55AA; d_req = 1'b1; d_addr = 32'h20000020;
        for (int i = 0; i < 9; i++) begin
            at_sample();
            if (i == 3) chk("t5_reset_outputs", all_out, 160'd0);
            chk("t5_d_ack", d_ack, 1'b0);
            if (i >= 4) begin
                chk("t5_if_ack", if_ack, (i == 7));
                chk("t5_mem_start", mem_start, (i == 5));
            end
            if (i == 5) chk("t5_mem_addr", mem_addr, 32'h400);
            if (i == 7) chk("t5_if_rdata", if_rdata, 32'hCAFEF00D);
            cyc_edge();
            if (i == 2) begin
                rst = 1'b1; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h400;
                cfg_busy = 0; cfg_rdata = 32'hCAFEF00D;
            end
            if (i == 3) rst = 1'b0;
            if (i == 7) if_req = 1'b0;
        end

        // Fetch arrives during a data WAIT; address sampled in IDLE only.
        cfg_busy = 4; cfg_rdata = 32'h0BADCAFE; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20000030;
        for (int i = 0; i < 17; i++) begin
            at_sample();
            chk("t6_d_ack", d_ack, (i == 7));
            chk("t6_if_ack", if_ack, (i == 15));
            chk("t6_mem_start", mem_start, (i == 1 || i == 9));
            if (i == 9 || i == 12) chk("t6_mem_addr", mem_addr, 32'h504);
            if (i == 15) chk("t6_if_rdata", if_rdata, 32'h0BADCAFE);
            cyc_edge();
            if (i == 2)  begin if_req = 1'b1; if_addr = 32'h500; end
            if (i == 4)  if_addr = 32'h504;
            if (i == 7)  d_req = 1'b0;
            if (i == 9)  if_addr = 32'h600;
            if (i == 15) if_req = 1'b0;
        end

        repeat (3) at_sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
